// File: rtl/sha_ctrl_seq_if.sv
// Message-source / digest-consumer handshake and datapath control bundle for sha_ctrl_seq.
interface sha_ctrl_seq_if #(
    parameter int unsigned RND_W  = 6,
    parameter int unsigned WIDX_W = 4
);
    logic              i_start;
    logic              i_blk_valid;
    logic              i_blk_last;
    logic              o_blk_ready;
    logic              o_ld_en;
    logic [WIDX_W-1:0] o_ld_idx;
    logic              o_rnd_en;
    logic [RND_W-1:0]  o_rnd_idx;
    logic              o_sched_sel;
    logic              o_init_sel;
    logic              o_upd_en;
    logic              o_busy;
    logic              o_valid;
    logic              i_ready;

    modport master (
        output i_start, i_blk_valid, i_blk_last, i_ready,
        input  o_blk_ready, o_ld_en, o_ld_idx, o_rnd_en, o_rnd_idx,
               o_sched_sel, o_init_sel, o_upd_en, o_busy, o_valid
    );

    modport slave (
        input  i_start, i_blk_valid, i_blk_last, i_ready,
        output o_blk_ready, o_ld_en, o_ld_idx, o_rnd_en, o_rnd_idx,
               o_sched_sel, o_init_sel, o_upd_en, o_busy, o_valid
    );
endinterface

// File: rtl/sha_ctrl_seq.sv
// SHA datapath control sequencer: streaming block load, round counting, hash chaining, digest handshake.
// Optional macro SHA_CTRL_ABORT_EN adds the i_abort port.
module sha_ctrl_seq #(
    parameter int unsigned NUM_ROUNDS = 64,
    parameter int unsigned BLK_WORDS  = 16,
    parameter int unsigned RND_W      = 6,
    parameter int unsigned WIDX_W     = 4
) (
    input  logic          usr_clk,
    input  logic          usr_reset,
    sha_ctrl_seq_if.slave bus
`ifdef SHA_CTRL_ABORT_EN
    ,
    input  logic          i_abort
`endif
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ROUND  = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [WIDX_W-1:0] LAST_WORD   = WIDX_W'(BLK_WORDS - 1);
    localparam logic [RND_W-1:0]  LAST_RND    = RND_W'(NUM_ROUNDS - 1);
    localparam logic [RND_W-1:0]  SCHED_START = RND_W'(BLK_WORDS);

    state_t            state, state_n;
    logic [WIDX_W-1:0] word_cnt, word_n;
    logic [RND_W-1:0]  rnd_cnt, rnd_n;
    logic              first_blk, first_n;
    logic              last_blk, last_n;
    logic              blk_ready;
    logic              ld_en;
    logic              abort;

`ifdef SHA_CTRL_ABORT_EN
    assign abort = i_abort & ((state == LOAD) | (state == ROUND) | (state == UPDATE));
`else
    assign abort = 1'b0;
`endif

    assign blk_ready = (state == LOAD);
    assign ld_en     = bus.i_blk_valid & blk_ready;

    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            state     <= IDLE;
            word_cnt  <= '0;
            rnd_cnt   <= '0;
            first_blk <= 1'b1;
            last_blk  <= 1'b0;
        end else begin
            state     <= state_n;
            word_cnt  <= word_n;
            rnd_cnt   <= rnd_n;
            first_blk <= first_n;
            last_blk  <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        word_n  = word_cnt;
        rnd_n   = rnd_cnt;
        first_n = first_blk;
        last_n  = last_blk;
        unique case (state)
            IDLE: begin
                if (bus.i_start) begin
                    state_n = LOAD;
                    first_n = 1'b1;
                    last_n  = 1'b0;
                    word_n  = '0;
                    rnd_n   = '0;
                end
            end
            LOAD: begin
                if (ld_en) begin
                    if (word_cnt == LAST_WORD) begin
                        last_n  = bus.i_blk_last;
                        word_n  = '0;
                        state_n = ROUND;
                    end else begin
                        word_n = word_cnt + 1'b1;
                    end
                end
            end
            ROUND: begin
                if (rnd_cnt == LAST_RND) begin
                    rnd_n   = '0;
                    state_n = UPDATE;
                end else begin
                    rnd_n = rnd_cnt + 1'b1;
                end
            end
            UPDATE: begin
                first_n = 1'b0;
                state_n = last_blk ? DONE : LOAD;
            end
            DONE: begin
                if (bus.i_ready) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                word_n  = '0;
                rnd_n   = '0;
            end
        endcase
        // Abort overrides whatever the state decode chose this cycle.
        if (abort) begin
            state_n = IDLE;
            word_n  = '0;
            rnd_n   = '0;
            first_n = 1'b1;
            last_n  = 1'b0;
        end
    end

    always_comb begin
        bus.o_blk_ready = blk_ready;
        bus.o_ld_en     = ld_en;
        bus.o_ld_idx    = blk_ready ? word_cnt : '0;
        bus.o_rnd_en    = (state == ROUND);
        bus.o_rnd_idx   = (state == ROUND) ? rnd_cnt : '0;
        bus.o_sched_sel = (state == ROUND) && (rnd_cnt >= SCHED_START);
        bus.o_init_sel  = first_blk;
        bus.o_upd_en    = (state == UPDATE) & ~abort;
        bus.o_busy      = (state != IDLE);
        bus.o_valid     = (state == DONE);
    end
endmodule

// File: tb/tb_sha_ctrl_seq.sv
// Randomized self-checking bench for sha_ctrl_seq; expected traces come from a cycle-timeline message model.
module tb_sha_ctrl_seq;
    localparam int MAXC = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic abort = 1'b0;
    always #5 clk = ~clk;

    sha_ctrl_seq_if #(.RND_W(6), .WIDX_W(4)) bus ();

    sha_ctrl_seq #(
        .NUM_ROUNDS(64),
        .BLK_WORDS (16),
        .RND_W     (6),
        .WIDX_W    (4)
    ) dut (
        .usr_clk  (clk),
        .usr_reset(rst),
        .bus      (bus)
`ifdef SHA_CTRL_ABORT_EN
        ,
        .i_abort  (abort)
`endif
    );

    logic        s_start [MAXC];
    logic        s_valid [MAXC];
    logic        s_last  [MAXC];
    logic        s_ready [MAXC];
    logic        s_rst   [MAXC];
    logic        s_abort [MAXC];
    logic [17:0] e_vec   [MAXC];
    logic [17:0] obs     [MAXC];
    int          stall_tab [4][16];
    int          ncyc;
    logic        m_first;
    int          passed = 0;
    int          total = 0;

    function automatic logic [17:0] pack(input logic busy, rdy, lden, input logic [3:0] li,
                                         input logic re, input logic [5:0] ri,
                                         input logic ss, is, ue, v);
        return {busy, rdy, lden, li, re, ri, ss, is, ue, v};
    endfunction

    function automatic logic [17:0] idle_vec(input logic init);
        return pack(0, 0, 0, 4'd0, 0, 6'd0, 0, init, 0, 0);
    endfunction

    task automatic clear_stalls();
        for (int b = 0; b < 4; b++)
            for (int w = 0; w < 16; w++) stall_tab[b][w] = 0;
    endtask

    // Lays out one message on a cycle timeline: stalls, word loads, 64 rounds, update, digest wait.
    task automatic build(input int t0, input int nblk, input int rdelay, input logic start_in_done);
        int t;
        logic ib;
        for (int c = 0; c < MAXC; c++) begin
            s_start[c] = 1'b0;
            s_valid[c] = 1'($urandom % 2);
            s_last[c]  = 1'($urandom % 2);
            s_ready[c] = 1'($urandom % 2);
            s_rst[c]   = 1'b0;
            s_abort[c] = 1'b0;
            e_vec[c]   = idle_vec(c <= t0 ? m_first : 1'b0);
        end
        s_start[t0] = 1'b1;
        t = t0 + 1;
        for (int b = 0; b < nblk; b++) begin
            ib = (b == 0);
            for (int w = 0; w < 16; w++) begin
                for (int k = 0; k < stall_tab[b][w]; k++) begin
                    s_valid[t] = 1'b0;
                    s_start[t] = 1'($urandom % 2);
                    e_vec[t] = pack(1, 1, 0, 4'(w), 0, 6'd0, 0, ib, 0, 0);
                    t++;
                end
                s_valid[t] = 1'b1;
                s_last[t]  = (w == 15) ? (b == nblk - 1) : 1'($urandom % 2);
                s_start[t] = 1'($urandom % 2);
                e_vec[t] = pack(1, 1, 1, 4'(w), 0, 6'd0, 0, ib, 0, 0);
                t++;
            end
            for (int r = 0; r < 64; r++) begin
                s_start[t] = 1'($urandom % 2);
                e_vec[t] = pack(1, 0, 0, 4'd0, 1, 6'(r), r >= 16, ib, 0, 0);
                t++;
            end
            s_start[t] = 1'($urandom % 2);
            e_vec[t] = pack(1, 0, 0, 4'd0, 0, 6'd0, 0, ib, 1, 0);
            t++;
        end
        for (int k = 0; k <= rdelay; k++) begin
            s_ready[t] = (k == rdelay);
            s_start[t] = start_in_done;
            e_vec[t] = pack(1, 0, 0, 4'd0, 0, 6'd0, 0, 0, 0, 1);
            t++;
        end
        ncyc = t + 3;
        m_first = 1'b0;
    endtask

    task automatic run_trace();
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            rst             = s_rst[c];
            abort           = s_abort[c];
            bus.i_start     = s_start[c];
            bus.i_blk_valid = s_valid[c];
            bus.i_blk_last  = s_last[c];
            bus.i_ready     = s_ready[c];
            @(negedge clk);
            obs[c] = pack(bus.o_busy, bus.o_blk_ready, bus.o_ld_en, bus.o_ld_idx, bus.o_rnd_en,
                          bus.o_rnd_idx, bus.o_sched_sel, bus.o_init_sel, bus.o_upd_en, bus.o_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; abort = 1'b0;
        bus.i_start = 1'b0; bus.i_blk_valid = 1'b0; bus.i_blk_last = 1'b0; bus.i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_start = 1'b1; bus.i_blk_valid = 1'b1; bus.i_blk_last = 1'b1; bus.i_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (obs_now() !== idle_vec(1'b1))
            $display("FAIL reset_hold got %h exp %h", obs_now(), idle_vec(1'b1));
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.i_start = 1'b0; bus.i_blk_valid = 1'b0; bus.i_blk_last = 1'b0; bus.i_ready = 1'b0;
        @(negedge clk);
        total++;
        if (obs_now() !== idle_vec(1'b1))
            $display("FAIL reset_release got %h exp %h", obs_now(), idle_vec(1'b1));
        else passed++;
        m_first = 1'b1;
    endtask

    function automatic logic [17:0] obs_now();
        return pack(bus.o_busy, bus.o_blk_ready, bus.o_ld_en, bus.o_ld_idx, bus.o_rnd_en,
                    bus.o_rnd_idx, bus.o_sched_sel, bus.o_init_sel, bus.o_upd_en, bus.o_valid);
    endfunction

    task automatic test_single_block();
        int first_v, first_u;
        clear_stalls();
        build(0, 1, 0, 1'b0);
        run_trace();
        first_v = -1; first_u = -1;
        for (int c = 0; c < ncyc; c++) begin
            total++;
            if (obs[c] !== e_vec[c]) $display("FAIL single c=%0d got %h exp %h", c, obs[c], e_vec[c]);
            else passed++;
            if (first_v < 0 && obs[c][0]) first_v = c;
            if (first_u < 0 && obs[c][1]) first_u = c;
        end
        total++;
        if (first_v !== 82) $display("FAIL single_valid_cycle got %0d exp 82", first_v); else passed++;
        total++;
        if (first_u !== 81) $display("FAIL single_upd_cycle got %0d exp 81", first_u); else passed++;
    endtask

    task automatic test_two_block();
        int upd_c[$];
        int first_v;
        clear_stalls();
        build(0, 2, 0, 1'b0);
        run_trace();
        first_v = -1;
        for (int c = 0; c < ncyc; c++) begin
            total++;
            if (obs[c] !== e_vec[c]) $display("FAIL two_block c=%0d got %h exp %h", c, obs[c], e_vec[c]);
            else passed++;
            if (obs[c][1]) upd_c.push_back(c);
            if (first_v < 0 && obs[c][0]) first_v = c;
        end
        total++;
        if (upd_c.size() != 2 || upd_c[0] != 81 || upd_c[1] != 162)
            $display("FAIL two_block_upd got n=%0d first=%0d exp n=2 at 81,162", upd_c.size(),
                     upd_c.size() > 0 ? upd_c[0] : -1);
        else passed++;
        total++;
        if (first_v !== 163) $display("FAIL two_block_valid got %0d exp 163", first_v); else passed++;
    endtask

    task automatic test_load_stall();
        int first_v;
        clear_stalls();
        stall_tab[0][3] = 2;
        stall_tab[0][10] = 2;
        build(0, 1, 0, 1'b0);
        run_trace();
        first_v = -1;
        for (int c = 0; c < ncyc; c++) begin
            total++;
            if (obs[c] !== e_vec[c]) $display("FAIL load_stall c=%0d got %h exp %h", c, obs[c], e_vec[c]);
            else passed++;
            if (first_v < 0 && obs[c][0]) first_v = c;
        end
        total++;
        if (first_v !== 86) $display("FAIL load_stall_valid got %0d exp 86", first_v); else passed++;
    endtask

    task automatic test_backpressure();
        int vcount;
        clear_stalls();
        build(1, 1, 5, 1'b1);
        run_trace();
        vcount = 0;
        for (int c = 0; c < ncyc; c++) begin
            total++;
            if (obs[c] !== e_vec[c]) $display("FAIL backpressure c=%0d got %h exp %h", c, obs[c], e_vec[c]);
            else passed++;
            if (obs[c][0]) vcount++;
        end
        total++;
        if (vcount !== 6) $display("FAIL backpressure_valid_len got %0d exp 6", vcount); else passed++;
    endtask

    task automatic test_reset_mid();
        int rc, first_v;
        clear_stalls();
        build(1, 1, 0, 1'b0);
        rc = 1 + 1 + 16 + 30;
        s_rst[rc] = 1'b1;
        for (int c = rc + 1; c < MAXC; c++) begin
            s_start[c] = 1'b0;
            e_vec[c] = idle_vec(1'b1);
        end
        ncyc = rc + 4;
        run_trace();
        for (int c = 0; c < ncyc; c++) begin
            total++;
            if (obs[c] !== e_vec[c]) $display("FAIL reset_mid c=%0d got %h exp %h", c, obs[c], e_vec[c]);
            else passed++;
        end
        m_first = 1'b1;
        build(0, 1, 0, 1'b0);
        run_trace();
        first_v = -1;
        for (int c = 0; c < ncyc; c++) begin
            total++;
            if (obs[c] !== e_vec[c]) $display("FAIL reset_mid_rerun c=%0d got %h exp %h", c, obs[c], e_vec[c]);
            else passed++;
            if (first_v < 0 && obs[c][0]) first_v = c;
        end
        total++;
        if (first_v !== 82) $display("FAIL reset_mid_rerun_valid got %0d exp 82", first_v); else passed++;
    endtask

`ifdef SHA_CTRL_ABORT_EN
    task automatic test_abort();
        int ac;
        clear_stalls();
        build(1, 1, 0, 1'b0);
        ac = 1 + 1 + 7;
        s_abort[ac] = 1'b1;
        for (int c = ac + 1; c < MAXC; c++) begin
            s_start[c] = 1'b0;
            e_vec[c] = idle_vec(1'b1);
        end
        ncyc = ac + 4;
        run_trace();
        for (int c = 0; c < ncyc; c++) begin
            total++;
            if (obs[c] !== e_vec[c]) $display("FAIL abort c=%0d got %h exp %h", c, obs[c], e_vec[c]);
            else passed++;
        end
        m_first = 1'b1;
        build(0, 1, 0, 1'b0);
        run_trace();
        for (int c = 0; c < ncyc; c++) begin
            total++;
            if (obs[c] !== e_vec[c]) $display("FAIL abort_next c=%0d got %h exp %h", c, obs[c], e_vec[c]);
            else passed++;
        end
    endtask
`endif

    task automatic test_random();
        for (int m = 0; m < 6; m++) begin
            clear_stalls();
            for (int b = 0; b < 4; b++)
                for (int w = 0; w < 16; w++)
                    if ($urandom_range(0, 3) == 0) stall_tab[b][w] = $urandom_range(1, 3);
            build($urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 4), 1'($urandom % 2));
            run_trace();
            for (int c = 0; c < ncyc; c++) begin
                total++;
                if (obs[c] !== e_vec[c])
                    $display("FAIL random m=%0d c=%0d got %h exp %h", m, c, obs[c], e_vec[c]);
                else passed++;
            end
        end
    endtask

    initial begin
        bus.i_start = 1'b0; bus.i_blk_valid = 1'b0; bus.i_blk_last = 1'b0; bus.i_ready = 1'b0;
        m_first = 1'b1;
        test_reset();
        test_single_block();
        test_two_block();
        test_load_stall();
        test_backpressure();
        test_reset_mid();
`ifdef SHA_CTRL_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sha_ctrl_seq.md
Name: sha_ctrl_seq

Overview:
Parametrised control sequencer for the SHA hashing datapath. It replaces the single-shot start/counter-flag controller with an internal word/round counter and a streaming message-block load phase. It supports multi-block messages with hash chaining and adds a valid/ready result handshake. It sits between the message source and the message-schedule / round-function datapath and drives all datapath selects and enables.

Parameters:
NUM_ROUNDS, 64, number of compression rounds per block (>= BLK_WORDS+1)
BLK_WORDS, 16, message words loaded per block (power of 2)
RND_W, 6, width of round index; must satisfy 2**RND_W >= NUM_ROUNDS
WIDX_W, 4, width of load-word index; must satisfy 2**WIDX_W == BLK_WORDS

Ports:
usr_clk  in  1  system clock, all logic on rising edge
usr_reset  in  1  synchronous reset, active-high
i_start  in  1  begin a new message; sampled only in IDLE
i_blk_valid  in  1  message word present on datapath input
i_blk_last  in  1  current block is final block of message; sampled with final word of block
o_blk_ready  out  1  controller accepts message words
o_ld_en  out  1  write current word into schedule register at o_ld_idx
o_ld_idx  out  WIDX_W  index of word being loaded
o_rnd_en  out  1  round function / schedule advance enable
o_rnd_idx  out  RND_W  current round number
o_sched_sel  out  1  0: W_t from loaded word, 1: W_t from schedule recurrence
o_init_sel  out  1  1: working vars/hash from IV, 0: from chained hash
o_upd_en  out  1  add working vars into hash registers
o_busy  out  1  high in any state other than IDLE
o_valid  out  1  final digest available
i_ready  in  1  consumer accepts digest

Behaviour:
- Reset (usr_clk edge with usr_reset=1): state IDLE, word and round counters 0, first_blk=1, last_blk=0. All outputs 0, except o_init_sel=1.
- States: IDLE, LOAD, ROUND, UPDATE, DONE. Outputs are a Moore decode of state/counters, except o_ld_en.
- o_ld_en = i_blk_valid & o_blk_ready (combinational).
- IDLE: no enables. i_start=1 -> LOAD; first_blk<=1, counters<=0.
- LOAD: o_blk_ready=1, o_ld_idx=word counter. Word counter increments on o_ld_en only; stalls without error while i_blk_valid=0.
  - On o_ld_en with word counter == BLK_WORDS-1: last_blk<=i_blk_last, word counter<=0, go to ROUND.
  - i_blk_last on other words is ignored.
- ROUND: o_rnd_en=1, o_rnd_idx=round counter, o_sched_sel=(round counter >= BLK_WORDS). The counter advances every cycle with no stall.
  - At round counter == NUM_ROUNDS-1: round counter<=0, go to UPDATE.
- UPDATE: exactly one cycle, o_upd_en=1, first_blk<=0.
  - last_blk=1 -> DONE; else -> LOAD.
- o_init_sel = first_blk: high from LOAD through UPDATE of block 0, low for all later blocks.
- DONE: o_valid=1, held stable until i_ready=1. Transfer on o_valid&i_ready -> IDLE.
  - i_ready is ignored in other states.
  - i_start in DONE is ignored, not queued.
- Zero-stall latency: i_start at cycle 0 -> LOAD cycles 1..BLK_WORDS -> ROUND BLK_WORDS+1..BLK_WORDS+NUM_ROUNDS -> UPDATE next cycle.
  - Per block: BLK_WORDS+NUM_ROUNDS+1 cycles. Default: o_valid first high at cycle 82 for one block, 163 for two.
- Round counter wrap: never exceeds NUM_ROUNDS-1. Word counter wraps to 0 only via the final-word transition.
- Reset mid-operation (any state): next cycle IDLE with reset values. Partial block and chaining state are discarded.
- Unreachable state encodings -> IDLE.

Optional Feature:
Macro SHA_CTRL_ABORT_EN adds input port i_abort (1 bit).
- Defined: i_abort=1 in LOAD, ROUND or UPDATE -> IDLE next cycle, counters 0, first_blk=1, no o_upd_en or o_valid. In IDLE/DONE i_abort has no effect. i_abort takes priority over all same-cycle transitions.
- Not defined: no port, behaviour exactly as above.

Test Plan:
- Reset then i_start pulse, 16 consecutive valid words with i_blk_last=1 on word 15 -> o_ld_idx 0..15, o_rnd_idx 0..63, o_sched_sel rises at round 16, o_upd_en at cycle 81, o_valid at cycle 82, o_init_sel=1 throughout.
- Two-block message, i_blk_last=0 then 1 -> o_upd_en at 81 and 162, o_init_sel drops after cycle 81, o_valid at 163.
- Load stalls: i_blk_valid low on words 3 and 10 for 2 cycles each -> o_ld_idx holds, o_valid delayed exactly 4 cycles to 86.
- Output backpressure: i_ready=0 for 5 cycles in DONE -> o_valid held 6 cycles; i_start pulses during DONE ignored; returns to IDLE.
- usr_reset asserted at round 30 -> next cycle all outputs 0 except o_init_sel=1. A new i_start runs a full 82-cycle sequence.
- With SHA_CTRL_ABORT_EN: i_abort at load word 7 -> IDLE next cycle, no o_upd_en. The next message has o_init_sel=1.
